vault_phase_sequencer: RTL

Top-level controller for the vault puzzle chain. It arms NUM_PHASES phase FSMs one at a time, clears each before arming, and watches the armed phase's done/fail pair. It enforces a per-phase timeout and a retry budget, and drives the vault-open and lockout indications. It sits between the phase FSMs and the vault output/indicator logic.

---
 rtl/vault_phase_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/vault_phase_sequencer.sv
// Sequences the vault puzzle phase FSMs one at a time. Each phase gets a clear pulse
// before it is armed; the sequencer then enforces a WAIT timeout, a retry budget and a lockout hold.
module vault_phase_sequencer #(
  parameter int NUM_PHASES     = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_RETRIES    = 3,
  parameter int LOCKOUT_CYCLES = 5000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               relock,
  input  logic [NUM_PHASES-1:0]              phase_done,
  input  logic [NUM_PHASES-1:0]              phase_fail,
  output logic [NUM_PHASES-1:0]              phase_clear,
  output logic [NUM_PHASES-1:0]              phase_en,
  output logic [$clog2(NUM_PHASES)-1:0]      active_phase,
  output logic                               busy,
  output logic                               attempt_fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retries_left,
  output logic                               vault_open,
  output logic                               locked_out
);

  localparam int PW = $clog2(NUM_PHASES);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int LW = $clog2(LOCKOUT_CYCLES);

  localparam logic [PW-1:0]         LAST_PHASE  = PW'(NUM_PHASES - 1);
  localparam logic [TW-1:0]         TIMER_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0]         LOCK_LAST   = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [RW-1:0]         RETRY_FULL  = RW'(MAX_RETRIES);
  localparam logic [NUM_PHASES-1:0] ONE_HOT_LSB = NUM_PHASES'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT,
    S_OPEN,
    S_LOCKOUT
  } state_t;

  state_t                  state, state_nx;
  logic [PW-1:0]           phase_nx;
  logic [TW-1:0]           timer, timer_nx;
  logic [LW-1:0]           lock_cnt, lock_nx;
  logic [RW-1:0]           retries_nx;
  logic                    fail_nx;
  logic [NUM_PHASES-1:0]   onehot_nx;

  always_comb begin
    state_nx   = state;
    phase_nx   = active_phase;
    timer_nx   = timer;
    lock_nx    = lock_cnt;
    retries_nx = retries_left;
    fail_nx    = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_CLEAR;
          phase_nx = '0;
        end
      end

      S_CLEAR: begin
        timer_nx = '0;
        state_nx = S_WAIT;
      end

      S_WAIT: begin
        timer_nx = timer + TW'(1);
        // fail outranks timeout, which outranks done; other phases' flags are never looked at
        if (phase_fail[active_phase] || (timer == TIMER_LAST)) begin
          fail_nx    = 1'b1;
          retries_nx = (retries_left != '0) ? retries_left - RW'(1) : '0;
          if (retries_left == RW'(1)) begin
            state_nx = S_LOCKOUT;
            lock_nx  = '0;
          end else begin
            state_nx = S_CLEAR;
            phase_nx = '0;
          end
        end else if (phase_done[active_phase]) begin
          if (active_phase == LAST_PHASE) begin
            state_nx   = S_OPEN;
            retries_nx = RETRY_FULL;
          end else begin
            state_nx = S_CLEAR;
            phase_nx = active_phase + PW'(1);
          end
        end
      end

      S_OPEN: begin
        retries_nx = RETRY_FULL;
        if (relock) begin
          state_nx = S_IDLE;
          phase_nx = '0;
        end
      end

      S_LOCKOUT: begin
        if (lock_cnt == LOCK_LAST) begin
          state_nx   = S_IDLE;
          lock_nx    = '0;
          retries_nx = RETRY_FULL;
          phase_nx   = '0;
        end else begin
          lock_nx = lock_cnt + LW'(1);
        end
      end

      default: begin
        state_nx = S_IDLE;
        phase_nx = '0;
      end
    endcase
  end

  assign onehot_nx = ONE_HOT_LSB << phase_nx;

  // Outputs are decoded from the next state so they are registered yet line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      active_phase <= '0;
      timer        <= '0;
      lock_cnt     <= '0;
      retries_left <= RETRY_FULL;
      phase_clear  <= '0;
      phase_en     <= '0;
      busy         <= 1'b0;
      attempt_fail <= 1'b0;
      vault_open   <= 1'b0;
      locked_out   <= 1'b0;
    end else begin
      state        <= state_nx;
      active_phase <= phase_nx;
      timer        <= timer_nx;
      lock_cnt     <= lock_nx;
      retries_left <= retries_nx;
      phase_clear  <= (state_nx == S_CLEAR) ? onehot_nx : '0;
      phase_en     <= (state_nx == S_WAIT)  ? onehot_nx : '0;
      busy         <= (state_nx == S_CLEAR) || (state_nx == S_WAIT);
      attempt_fail <= fail_nx;
      vault_open   <= (state_nx == S_OPEN);
      locked_out   <= (state_nx == S_LOCKOUT);
    end
  end

endmodule
